// File: rtl/branch_target_cam.sv
// branch_target_cam
//   Programmable branch-target table with two lookup directions.
//   Forward: rd_idx -> rd_target/rd_valid, purely combinational, for fetch.
//   Reverse: srch_target -> srch_idx through a sequential scan with a
//   request/done handshake, for the loader/debugger.
//
// Ports
//   Clk          system clock, all state updates on the rising edge
//   Reset        synchronous active-high reset
//   wr_en        store wr_target into entry wr_idx and mark it valid
//   inv_en       clear the valid bit of entry wr_idx (wr_en wins)
//   wr_idx       entry selected for write/invalidate
//   wr_target    value written
//   rd_idx       forward lookup index
//   rd_target    forward result, 0 when the entry is invalid
//   rd_valid     valid bit of entry rd_idx
//   srch_req     start a reverse search (only looked at while idle)
//   srch_target  value to search, captured when the request is accepted
//   srch_busy    high while scanning and in the done cycle
//   srch_done    one-cycle pulse, search result is ready
//   srch_hit     match found; held until the next accepted request
//   srch_idx     lowest matching index, 0 on miss
module branch_target_cam #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int ADDR_W  = 12
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              wr_en,
   input  logic              inv_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [ADDR_W-1:0] wr_target,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [ADDR_W-1:0] rd_target,
   output logic              rd_valid,
   input  logic              srch_req,
   input  logic [ADDR_W-1:0] srch_target,
   output logic              srch_busy,
   output logic              srch_done,
   output logic              srch_hit,
   output logic [IDX_W-1:0]  srch_idx
);

   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [ADDR_W-1:0] tbl [ENTRIES];
   logic [ENTRIES-1:0] vld;

   state_t            state, state_n;
   logic [IDX_W-1:0]  cnt, cnt_n;
   logic [ADDR_W-1:0] tgt, tgt_n;
   logic              hit_n;
   logic [IDX_W-1:0]  idx_n;
   logic              scan_match;

   // Table storage: one write or invalidate per edge, no read bypass
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= '0;
         end
         vld <= '0;
      end else if (wr_en) begin
         tbl[wr_idx] <= wr_target;
         vld[wr_idx] <= 1'b1;
      end else if (inv_en) begin
         vld[wr_idx] <= 1'b0;
      end
   end

   // Forward lookup
   assign rd_valid  = vld[rd_idx];
   assign rd_target = vld[rd_idx] ? tbl[rd_idx] : '0;

   // Reverse scan compares against pre-edge contents, so a write landing
   // on a not-yet-visited entry is seen and one behind the cursor is not.
   assign scan_match = vld[cnt] && (tbl[cnt] == tgt);

   assign srch_busy = (state != IDLE);
   assign srch_done = (state == DONE);

   // Search control state
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         srch_hit <= 1'b0;
         srch_idx <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         srch_hit <= hit_n;
         srch_idx <= idx_n;
      end
   end

   // Captured search key is data only; it is always rewritten on acceptance
   always_ff @(posedge Clk) begin
      tgt <= tgt_n;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tgt_n   = tgt;
      hit_n   = srch_hit;
      idx_n   = srch_idx;
      case (state)
         IDLE: begin
            if (srch_req) begin
               tgt_n   = srch_target;
               cnt_n   = '0;
               hit_n   = 1'b0;
               idx_n   = '0;
               state_n = SCAN;
            end
         end
         SCAN: begin
            // Scan ascends from 0, so the first match is the lowest index
            if (scan_match) begin
               hit_n   = 1'b1;
               idx_n   = cnt;
               state_n = DONE;
            end else if (cnt == CNT_LAST) begin
               hit_n   = 1'b0;
               idx_n   = '0;
               state_n = DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_branch_target_cam.sv
module tb_branch_target_cam;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        wr_en, inv_en;
   logic [3:0]  wr_idx;
   logic [11:0] wr_target;
   logic [3:0]  rd_idx;
   logic [11:0] rd_target;
   logic        rd_valid;
   logic        srch_req;
   logic [11:0] srch_target;
   logic        srch_busy, srch_done, srch_hit;
   logic [3:0]  srch_idx;

   int checks = 0;
   int errors = 0;

   branch_target_cam #(.ENTRIES(16), .IDX_W(4), .ADDR_W(12)) dut (
      .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .inv_en(inv_en),
      .wr_idx(wr_idx), .wr_target(wr_target), .rd_idx(rd_idx),
      .rd_target(rd_target), .rd_valid(rd_valid), .srch_req(srch_req),
      .srch_target(srch_target), .srch_busy(srch_busy),
      .srch_done(srch_done), .srch_hit(srch_hit), .srch_idx(srch_idx)
   );

   always #5 Clk = ~Clk;

   // Behavioural table model: what the loader has written so far
   logic [11:0] mt [16];
   bit          mv [16];
   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) begin
            mt[i] <= 12'd0;
            mv[i] <= 1'b0;
         end
      end else if (wr_en) begin
         mt[wr_idx] <= wr_target;
         mv[wr_idx] <= 1'b1;
      end else if (inv_en) begin
         mv[wr_idx] <= 1'b0;
      end
   end

   typedef struct {
      logic        we;
      logic        ie;
      logic [3:0]  wi;
      logic [11:0] wt;
      logic [3:0]  ri;
      logic [11:0] et;
      logic        ev;
   } vec_t;
   vec_t vt [14];

   function automatic vec_t mkv(bit we, bit ie, int wi, int wt, int ri, int et, bit ev);
      vec_t v;
      v.we = we; v.ie = ie; v.wi = 4'(wi); v.wt = 12'(wt);
      v.ri = 4'(ri); v.et = 12'(et); v.ev = ev;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clk_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_rd_model(input string nm);
      logic [11:0] e;
      e = mv[rd_idx] ? mt[rd_idx] : 12'd0;
      chk({nm, " rd_target"}, 32'(rd_target), 32'(e));
      chk({nm, " rd_valid"}, 32'(rd_valid), 32'(mv[rd_idx]));
   endtask

   // Issue a search and time the done pulse. Optional writes of wv at scan
   // cycles wa_n/wb_n and a stray request at cycle rq_n (all 0 = none).
   task automatic do_search(input string nm, input logic [11:0] tgt,
                            input bit ehit, input int eidx, input int elat,
                            input int wa_n, input int wa_i,
                            input int wb_n, input int wb_i,
                            input logic [11:0] wv, input int rq_n);
      int lat;
      bit busy_bad;
      lat = 0;
      busy_bad = 0;
      srch_req = 1'b1;
      srch_target = tgt;
      clk_step();
      srch_req = 1'b0;
      srch_target = 12'($urandom);
      for (int n = 1; n <= 40; n++) begin
         if (!srch_busy) busy_bad = 1;
         if (srch_done) begin
            lat = n;
            break;
         end
         wr_en = (n == wa_n) || (n == wb_n);
         wr_idx = (n == wa_n) ? 4'(wa_i) : 4'(wb_i);
         wr_target = wv;
         srch_req = (n == rq_n);
         if (n == rq_n) srch_target = 12'd2;
         clk_step();
      end
      wr_en = 1'b0;
      srch_req = 1'b0;
      chk({nm, " latency"}, 32'(lat), 32'(elat));
      chk({nm, " hit"}, 32'(srch_hit), 32'(ehit));
      chk({nm, " idx"}, 32'(srch_idx), 32'(eidx));
      chk({nm, " busy during scan"}, 32'(busy_bad), 32'd0);
      clk_step();
      chk({nm, " done after"}, 32'(srch_done), 32'd0);
      chk({nm, " busy after"}, 32'(srch_busy), 32'd0);
      chk({nm, " hit held"}, 32'(srch_hit), 32'(ehit));
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] pool [5];
      int dones;
      Reset = 1'b1; wr_en = 0; inv_en = 0; wr_idx = 0; wr_target = 0;
      rd_idx = 0; srch_req = 0; srch_target = 0;
      pool[0] = 12'h2a5; pool[1] = 12'hfff; pool[2] = 12'h000;
      pool[3] = 12'h7c1; pool[4] = 12'h555;

      vt[0]  = mkv(1, 0, 0, 2,   0, 0,   0);
      vt[1]  = mkv(1, 0, 1, 159, 0, 2,   1);
      vt[2]  = mkv(1, 0, 2, 177, 1, 159, 1);
      vt[3]  = mkv(1, 0, 3, 181, 2, 177, 1);
      vt[4]  = mkv(1, 0, 4, 185, 3, 181, 1);
      vt[5]  = mkv(1, 0, 5, 191, 3, 181, 1);
      vt[6]  = mkv(1, 0, 3, 200, 3, 181, 1);
      vt[7]  = mkv(0, 0, 0, 0,   3, 200, 1);
      vt[8]  = mkv(1, 0, 3, 181, 5, 191, 1);
      vt[9]  = mkv(0, 1, 5, 0,   5, 191, 1);
      vt[10] = mkv(1, 1, 5, 191, 5, 0,   0);
      vt[11] = mkv(0, 0, 0, 0,   5, 191, 1);
      vt[12] = mkv(0, 0, 0, 0,   6, 0,   0);
      vt[13] = mkv(0, 1, 6, 0,   4, 185, 1);

      // Reset state
      clk_step();
      clk_step();
      Reset = 1'b0;
      chk("reset busy", 32'(srch_busy), 32'd0);
      chk("reset done", 32'(srch_done), 32'd0);
      chk("reset hit", 32'(srch_hit), 32'd0);
      chk("reset idx", 32'(srch_idx), 32'd0);
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         chk("reset rd_target", 32'(rd_target), 32'd0);
         chk("reset rd_valid", 32'(rd_valid), 32'd0);
         clk_step();
      end

      // Table-driven load / forward read vectors (reads see pre-edge contents)
      for (int i = 0; i < 14; i++) begin
         wr_en = vt[i].we; inv_en = vt[i].ie; wr_idx = vt[i].wi;
         wr_target = vt[i].wt; rd_idx = vt[i].ri;
         #2;
         chk($sformatf("vec%0d rd_target", i), 32'(rd_target), 32'(vt[i].et));
         chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vt[i].ev));
         clk_step();
      end
      wr_en = 0; inv_en = 0;

      do_search("srch185", 12'd185, 1, 4, 6, 0, 0, 0, 0, 12'd0, 0);

      wr_en = 1; wr_idx = 4'd9; wr_target = 12'd177;
      clk_step();
      wr_en = 0;
      do_search("dup177", 12'd177, 1, 2, 4, 0, 0, 0, 0, 12'd0, 0);
      inv_en = 1; wr_idx = 4'd2;
      clk_step();
      inv_en = 0;
      do_search("inv177", 12'd177, 1, 9, 11, 0, 0, 0, 0, 12'd0, 0);

      // Write behind the cursor (idx1) is missed, ahead of it (idx7) is seen
      do_search("scanwr300", 12'd300, 1, 7, 9, 2, 1, 3, 7, 12'd300, 0);

      // Miss with a stray request mid-scan
      do_search("miss999", 12'd999, 0, 0, 17, 0, 0, 0, 0, 12'd0, 5);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (srch_done) dones++;
         clk_step();
      end
      chk("miss999 extra done", 32'(dones), 32'd0);

      // Randomized writes/reads/searches against the model
      for (int it = 0; it < 25; it++) begin
         for (int c = 0; c < 4; c++) begin
            wr_en = 1'($urandom_range(0, 1));
            inv_en = ($urandom_range(0, 3) == 0);
            wr_idx = 4'($urandom);
            wr_target = pool[$urandom_range(0, 3)];
            rd_idx = 4'($urandom);
            #1;
            chk_rd_model("rand fwd");
            clk_step();
         end
         wr_en = 0; inv_en = 0;
         begin
            logic [11:0] t;
            int k;
            t = pool[$urandom_range(0, 4)];
            k = -1;
            for (int i = 0; i < 16; i++) begin
               if (k < 0 && mv[i] && mt[i] == t) k = i;
            end
            if (k < 0) do_search("rand miss", t, 0, 0, 17, 0, 0, 0, 0, 12'd0, 0);
            else do_search("rand hit", t, 1, k, 2 + k, 0, 0, 0, 0, 12'd0, 0);
         end
      end

      // Reset in the middle of a scan (cnt == 5)
      srch_req = 1'b1; srch_target = 12'd999;
      clk_step();
      srch_req = 1'b0;
      for (int i = 0; i < 5; i++) clk_step();
      chk("midreset busy before", 32'(srch_busy), 32'd1);
      Reset = 1'b1;
      clk_step();
      Reset = 1'b0;
      chk("midreset busy", 32'(srch_busy), 32'd0);
      chk("midreset done", 32'(srch_done), 32'd0);
      chk("midreset hit", 32'(srch_hit), 32'd0);
      chk("midreset idx", 32'(srch_idx), 32'd0);
      dones = 0;
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         if (srch_done) dones++;
         chk("midreset rd_target", 32'(rd_target), 32'd0);
         chk("midreset rd_valid", 32'(rd_valid), 32'd0);
         clk_step();
      end
      chk("midreset no done", 32'(dones), 32'd0);
      do_search("after reset 2", 12'd2, 0, 0, 17, 0, 0, 0, 0, 12'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_target_cam.md
Name: branch_target_cam

Overview:
- Programmable branch-target table with two lookup directions:
  - Forward: a 4-bit branch index returns a 12-bit target.
  - Reverse: a 12-bit target returns its 4-bit index.
- Written at boot or at program switch by the loader, one entry per cycle.
- Forward port feeds the fetch stage.
- Reverse search is used by the assembler-side loader/debugger to encode a target PC back into a branch index. It runs as a sequential scan with a request/done handshake.

Parameters:
- ENTRIES, 16, number of table entries (power of 2).
- IDX_W, 4, index width = log2(ENTRIES).
- ADDR_W, 12, target/PC width.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write entry wr_idx this edge.
- inv_en  input  1  invalidate entry wr_idx this edge (wr_en has priority if both set).
- wr_idx  input  IDX_W  entry selected for write/invalidate.
- wr_target  input  ADDR_W  target value written.
- rd_idx  input  IDX_W  forward lookup index.
- rd_target  output  ADDR_W  forward result, combinational; 0 if entry invalid.
- rd_valid  output  1  valid bit of entry rd_idx.
- srch_req  input  1  start reverse search; sampled only in IDLE.
- srch_target  input  ADDR_W  value to search; latched when request accepted.
- srch_busy  output  1  high in SCAN and DONE.
- srch_done  output  1  one-cycle pulse: result is ready.
- srch_hit  output  1  match found; valid from srch_done until next accepted request.
- srch_idx  output  IDX_W  matching index; 0 on miss.

Behaviour:
- Reset (synchronous, takes effect on the edge):
  - All entries set to 0 and all valid bits cleared.
  - FSM goes to IDLE.
  - srch_busy, srch_done, srch_hit and srch_idx all go to 0.
  - Reset mid-scan aborts the search; no srch_done is produced.
- Writes:
  - wr_en stores wr_target and sets the valid bit.
  - inv_en clears the valid bit; stored data is don't-care.
  - Writes take one edge.
  - Forward read in the same cycle returns the old contents (no bypass).
- Forward path is purely combinational from rd_idx and table state: rd_target = valid ? entry : 0.
- FSM states are IDLE, SCAN, DONE.
- IDLE:
  - If srch_req is high, latch srch_target, set cnt=0 and go to SCAN.
  - Clear srch_hit and srch_idx on the same edge.
- SCAN:
  - Each cycle compares entry[cnt] (pre-edge contents) with the latched target, and requires the entry to be valid.
  - Match: set srch_hit=1, srch_idx=cnt, go to DONE.
  - No match and cnt==ENTRIES-1: set srch_hit=0, srch_idx=0, go to DONE.
  - Otherwise cnt increments by 1.
  - Lowest matching index wins.
- DONE: srch_done=1 for exactly one cycle, then return to IDLE.
- srch_req is ignored while srch_busy=1; there is no queuing.
- Latency, with the request sampled at the end of cycle T:
  - Hit at index k: srch_done in cycle T+2+k.
  - Miss: srch_done in cycle T+1+ENTRIES (T+17 by default).
- A back-to-back request asserted in the DONE cycle is ignored. The earliest new acceptance is the first IDLE cycle.
- Write during SCAN to an entry not yet compared is seen by the scan; a write to an already-compared entry is not.
- srch_target changes after acceptance have no effect.
- cnt is IDX_W wide. Termination is by the explicit cnt==ENTRIES-1 compare, never by wrap-around.
- Targets are unsigned ADDR_W bits; compare is full-width equality.

Test Plan:
- Reset then read all indices -> rd_valid=0 and rd_target=0 for idx 0..15; srch_busy=0.
- Load idx0..5 = 2,159,177,181,185,191; rd_idx=3 -> rd_target=181, rd_valid=1; same-cycle write of idx3=200 -> rd_target still 181 that cycle, 200 the next.
- Search 185 after the load -> srch_done exactly 6 cycles after the request cycle (k=4); srch_hit=1, srch_idx=4; srch_busy high during the scan.
- Write 177 into both idx2 and idx9, then search 177 -> srch_idx=2. Invalidate idx2 and search again -> srch_idx=9.
- Search 999 -> srch_done at request+17, srch_hit=0, srch_idx=0. A second srch_req during the scan -> ignored, exactly one done pulse.
- Assert Reset mid-scan at cnt=5 -> next cycle IDLE, no srch_done, table cleared; new request for 2 -> miss.
